dqs_oe_sequencer: RTL and testbench

//  Sequences the I and T pins of the differential tristate output buffers that drive DQS/DQS#,
//  and the T pins of the DQ output buffers, for DDR3 write bursts.

---
 rtl/ddr_phy_pkg.sv | 33 +++
 rtl/oe_down_counter.sv | 32 +++
 rtl/dqs_oe_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dqs_oe_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_phy_pkg.sv
// Shared DDR PHY definitions: write-sequencer state encoding and parameter limits.
// Configuration macro DQS_TRAIN_EN adds the TRAIN state to the encoding.
package ddr_phy_pkg;

  localparam int unsigned STATE_W  = 3;

  // Legal parameter ranges for dqs_oe_sequencer
  localparam int unsigned PRE_MIN  = 1;
  localparam int unsigned PRE_MAX  = 3;
  localparam int unsigned POST_MIN = 1;
  localparam int unsigned POST_MAX = 3;
  localparam int unsigned GAP_MAX  = 7;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    BURST = 3'd2,
    POST  = 3'd3,
    GAP   = 3'd4
`ifdef DQS_TRAIN_EN
    ,TRAIN = 3'd5
`endif
  } state_e;

  // True when the sequencer timing parameters are inside their legal ranges
  function automatic logic params_ok(input int unsigned pre, input int unsigned post,
                                     input int unsigned gap);
    return (pre >= PRE_MIN) && (pre <= PRE_MAX) &&
           (post >= POST_MIN) && (post <= POST_MAX) &&
           (gap <= GAP_MAX);
  endfunction

endpackage

// File: rtl/oe_down_counter.sv
// Loadable down-counter with terminal-count flag, shared by all sequencer phases.
// Ports:
//   clk, rst_n  clock, async active-low reset (count clears to 0)
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   tc_c        combinational: count is 0 (current phase ends this cycle)
module oe_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] count_q;

  // Count down, holding at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign tc_c = (count_q == '0);

endmodule

// File: rtl/dqs_oe_sequencer.sv
// DDR3 write-burst sequencer for the DQS/DQS# tristate buffer (I and T pins) and the
// DQ buffer T pins: preamble, toggling burst, postamble, turnaround gap, with
// seamless merging of back-to-back bursts.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   wr_req      write request, held until wr_ack
//   burst_len   beats in the burst (0 means 1), captured with wr_ack
//   wr_ack      one-cycle accept pulse
//   dqs_i       DQS buffer I pin
//   dqs_t       DQS buffer T pin (1 = tristate)
//   dq_t        DQ buffers T pin (1 = tristate)
//   busy        sequencer not idle
//   rd_ok       bus released, read path may start
//   train_en    write-leveling free-run request
// Macro DQS_TRAIN_EN: enables the TRAIN free-run state; otherwise train_en is ignored.
module dqs_oe_sequencer
  import ddr_phy_pkg::*;
#(
  parameter int unsigned PRE_CYCLES  = 1,
  parameter int unsigned POST_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned BL_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  input  logic [BL_W-1:0] burst_len,
  output logic            wr_ack,
  output logic            dqs_i,
  output logic            dqs_t,
  output logic            dq_t,
  output logic            busy,
  output logic            rd_ok,
  input  logic            train_en
);

  // Counter must hold both burst_len-1 and the largest gap count
  localparam int unsigned CNT_W = (BL_W > 3) ? BL_W : 3;

  // Elaboration-time rejection of illegal timing parameters
  if (!params_ok(PRE_CYCLES, POST_CYCLES, GAP_CYCLES)) begin : g_param_err
    $fatal(1, "dqs_oe_sequencer: illegal parameter (PRE_CYCLES=%0d POST_CYCLES=%0d GAP_CYCLES=%0d)",
           PRE_CYCLES, POST_CYCLES, GAP_CYCLES);
  end

  state_e            state_q, state_d;
  logic [BL_W-1:0]   blen_q, blen_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_tc_c;
  logic              wr_ack_d, dqs_i_d, dqs_t_d, dq_t_d, busy_d, rd_ok_d;

`ifndef DQS_TRAIN_EN
  logic unused_train_en;
  assign unused_train_en = train_en;
`endif

  // Counter preload for a burst: beats-1, with 0 beats treated as 1
  function automatic logic [CNT_W-1:0] beats_m1(input logic [BL_W-1:0] bl);
    return (bl == '0) ? '0 : CNT_W'(bl - BL_W'(1));
  endfunction

  oe_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc_c     (cnt_tc_c)
  );

  // Next state, counter control and next output values
  always_comb begin
    state_d  = state_q;
    blen_d   = blen_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    wr_ack_d = 1'b0;
    dqs_i_d  = 1'b0;
    dqs_t_d  = 1'b1;
    dq_t_d   = 1'b1;
    busy_d   = 1'b0;
    rd_ok_d  = 1'b1;

    case (state_q)
      IDLE: begin
`ifdef DQS_TRAIN_EN
        if (train_en) begin
          state_d = TRAIN;
        end else
`endif
        if (wr_req) begin
          state_d  = PRE;
          wr_ack_d = 1'b1;
          blen_d   = burst_len;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(PRE_CYCLES - 1);
        end
      end
      PRE: begin
        if (cnt_tc_c) begin
          state_d  = BURST;
          cnt_load = 1'b1;
          cnt_val  = beats_m1(blen_q);
        end
      end
      BURST: begin
        if (cnt_tc_c) begin
          cnt_load = 1'b1;
          if (wr_req) begin
            // Seamless merge: reload beats, stay in BURST
            wr_ack_d = 1'b1;
            blen_d   = burst_len;
            cnt_val  = beats_m1(burst_len);
          end else begin
            state_d = POST;
            cnt_val = CNT_W'(POST_CYCLES - 1);
          end
        end
      end
      POST: begin
        if (cnt_tc_c) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (cnt_tc_c) begin
          state_d = IDLE;
        end
      end
`ifdef DQS_TRAIN_EN
      TRAIN: begin
        if (!train_en) begin
          state_d  = POST;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(POST_CYCLES - 1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they register alongside it
    case (state_d)
      PRE, POST: begin
        dqs_t_d = 1'b0;
      end
      BURST: begin
        dqs_t_d = 1'b0;
        dq_t_d  = 1'b0;
        dqs_i_d = ~dqs_i;
      end
`ifdef DQS_TRAIN_EN
      TRAIN: begin
        dqs_t_d = 1'b0;
        dqs_i_d = ~dqs_i;
      end
`endif
      default: ;
    endcase
    busy_d  = (state_d != IDLE);
    rd_ok_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blen_q  <= '0;
      wr_ack  <= 1'b0;
      dqs_i   <= 1'b0;
      dqs_t   <= 1'b1;
      dq_t    <= 1'b1;
      busy    <= 1'b0;
      rd_ok   <= 1'b1;
    end else begin
      state_q <= state_d;
      blen_q  <= blen_d;
      wr_ack  <= wr_ack_d;
      dqs_i   <= dqs_i_d;
      dqs_t   <= dqs_t_d;
      dq_t    <= dq_t_d;
      busy    <= busy_d;
      rd_ok   <= rd_ok_d;
    end
  end

endmodule

// File: tb/tb_dqs_oe_sequencer.sv
// Self-checking bench for dqs_oe_sequencer (default parameters): directed vector
// table, hand-written reset/train sequences, and randomized requests against a
// schedule-queue reference model.
module tb_dqs_oe_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic [3:0] burst_len;
  logic       train_en;
  logic       wr_ack, dqs_i, dqs_t, dq_t, busy, rd_ok;

  always #5 clk = ~clk;

  dqs_oe_sequencer #(
    .PRE_CYCLES(1), .POST_CYCLES(1), .GAP_CYCLES(2), .BL_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .burst_len(burst_len),
    .wr_ack(wr_ack), .dqs_i(dqs_i), .dqs_t(dqs_t), .dq_t(dq_t),
    .busy(busy), .rd_ok(rd_ok), .train_en(train_en)
  );

  // Observed outputs, order {wr_ack, dqs_t, dqs_i, dq_t, busy, rd_ok}
  typedef logic [5:0] obs_t;
  localparam obs_t O_IDLE    = 6'b010101;
  localparam obs_t O_PRE     = 6'b000110;
  localparam obs_t O_PRE_ACK = 6'b100110;
  localparam obs_t O_POST    = 6'b000110;
  localparam obs_t O_GAP     = 6'b010110;
  localparam obs_t O_B1      = 6'b001010;
  localparam obs_t O_B0      = 6'b000010;
  localparam obs_t O_B1_ACK  = 6'b101010;
  localparam obs_t O_B0_ACK  = 6'b100010;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = {wr_ack, dqs_t, dqs_i, dq_t, busy, rd_ok};
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: ack/t/i/dq/busy/rd got %b required %b", name, $time, act, exp);
    end
  endtask

  // Directed vector table: inputs applied, one clock edge, outputs compared
  typedef struct {
    logic       wr;
    logic [3:0] bl;
    obs_t       exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic wr, input logic [3:0] bl, input obs_t e);
    vec_t v;
    v.wr = wr; v.bl = bl; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Reference model: queue of scheduled future output cycles
  typedef struct {
    obs_t o;
    logic last;
  } ent_t;
  ent_t sched[$];
  ent_t cur;

  function automatic ent_t mk(input obs_t o, input logic last);
    ent_t e;
    e.o = o; e.last = last;
    return e;
  endfunction

  function automatic void build(input bit from_idle, input logic start_lvl, input logic [3:0] bl);
    int n;
    logic lvl;
    sched.delete();
    n = (bl == 4'd0) ? 1 : int'(bl);
    if (from_idle) sched.push_back(mk(O_PRE, 1'b0));       // one preamble cycle
    lvl = start_lvl;
    for (int k = 0; k < n; k++) begin
      sched.push_back(mk({1'b0, 1'b0, lvl, 1'b0, 1'b1, 1'b0}, k == n - 1));
      lvl = ~lvl;
    end
    sched.push_back(mk(O_POST, 1'b0));                      // one postamble cycle
    for (int k = 0; k < 2; k++) sched.push_back(mk(O_GAP, 1'b0));
    sched[0].o[5] = 1'b1;                                   // ack on first cycle
  endfunction

  function automatic void model_step(input logic req, input logic [3:0] bl);
    bit idle;
    idle = (cur.o[1] == 1'b0);
    if (req && (idle || cur.last))
      build(idle, idle ? 1'b1 : ~cur.o[3], bl);
    if (sched.size() > 0) cur = sched.pop_front();
    else cur = mk(O_IDLE, 1'b0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; burst_len = 4'd0; train_en = 1'b0;

    // Reset state while rst_n is held low
    repeat (2) @(posedge clk);
    #1 check("reset_held", O_IDLE);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 check("reset_released", O_IDLE);
    end

    // Single burst of 4
    add(1, 4, O_PRE_ACK); add(0, 0, O_B1); add(0, 0, O_B0); add(0, 0, O_B1); add(0, 0, O_B0);
    add(0, 0, O_POST); add(0, 0, O_GAP); add(0, 0, O_GAP); add(0, 0, O_IDLE);
    // Merge 4 then 2, wr_req held through the last beat
    add(1, 4, O_PRE_ACK); add(1, 2, O_B1); add(1, 2, O_B0); add(1, 2, O_B1); add(1, 2, O_B0);
    add(1, 2, O_B1_ACK); add(0, 0, O_B0); add(0, 0, O_POST); add(0, 0, O_GAP); add(0, 0, O_GAP);
    add(0, 0, O_IDLE);
    // Requests during POST and GAP wait for IDLE
    add(1, 1, O_PRE_ACK); add(0, 0, O_B1); add(0, 0, O_POST); add(1, 3, O_GAP); add(1, 3, O_GAP);
    add(1, 3, O_IDLE); add(1, 3, O_PRE_ACK); add(0, 0, O_B1); add(0, 0, O_B0); add(0, 0, O_B1);
    add(0, 0, O_POST); add(0, 0, O_GAP); add(0, 0, O_GAP); add(0, 0, O_IDLE);
    // burst_len 0 behaves as 1
    add(1, 0, O_PRE_ACK); add(0, 0, O_B1); add(0, 0, O_POST); add(0, 0, O_GAP); add(0, 0, O_GAP);
    add(0, 0, O_IDLE);
    // Odd-length merge 3 then 1: level continues across boundary
    add(1, 3, O_PRE_ACK); add(1, 1, O_B1); add(1, 1, O_B0); add(1, 1, O_B1); add(1, 1, O_B0_ACK);
    add(0, 0, O_POST); add(0, 0, O_GAP); add(0, 0, O_GAP); add(0, 0, O_IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      wr_req = tbl[i].wr; burst_len = tbl[i].bl;
      @(posedge clk); #1 check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // Reset during burst beat 2: immediate tristate, no postamble afterwards
    wr_req = 1'b1; burst_len = 4'd4;
    @(posedge clk); #1 check("rstmid_pre", O_PRE_ACK);
    wr_req = 1'b0;
    @(posedge clk); #1 check("rstmid_b1", O_B1);
    @(posedge clk); #1 check("rstmid_b2", O_B0);
    #2 rst_n = 1'b0;
    #1 check("rstmid_async", O_IDLE);
    @(posedge clk); #1 check("rstmid_held", O_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1 check("rstmid_no_post", O_IDLE);

`ifdef DQS_TRAIN_EN
    // Write-leveling free run; wr_req ignored throughout
    train_en = 1'b1; wr_req = 1'b1; burst_len = 4'd4;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 check($sformatf("train[%0d]", k), {1'b0, 1'b0, (k % 2 == 0), 1'b1, 1'b1, 1'b0});
    end
    train_en = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1 check("train_post", O_POST);
    @(posedge clk); #1 check("train_gap0", O_GAP);
    @(posedge clk); #1 check("train_gap1", O_GAP);
    @(posedge clk); #1 check("train_idle", O_IDLE);
`endif

    // Randomized requester against the schedule model
    sched.delete();
    cur = mk(O_IDLE, 1'b0);
    wr_req = 1'b0; burst_len = 4'd0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      model_step(wr_req, burst_len);
      #1 check("rand", cur.o);
      if (wr_req && wr_ack) begin
        if ($urandom_range(1, 0) == 1) begin
          burst_len = 4'($urandom_range(15, 0));   // next request right away: may merge
        end else begin
          wr_req = 1'b0;
        end
      end else if (!wr_req && $urandom_range(3, 0) == 0) begin
        wr_req = 1'b1;
        burst_len = 4'($urandom_range(15, 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
